cargador_programa: RTL and testbench

Boot-time program loader and reset sequencer for the `rv32i` single-cycle core. It receives a length-prefixed, checksummed byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instructions and writes them into instruction memory. It holds the core in reset until a load completes with a correct checksum.

---
 rtl/cargador_programa.sv | 191 +++++++++++++++++++
 tb/tb_cargador_programa.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cargador_programa.sv
// -----------------------------------------------------------------------------
// cargador_programa
//
// Boot-time program loader and reset sequencer for the rv32i core.
// The loader receives a byte stream on a valid/ready handshake. The stream
// holds a 16-bit word count N (low byte first), then 4*N data bytes, then one
// checksum byte. The checksum is the XOR of all data bytes. The loader packs
// the data bytes little-endian into 32-bit words and writes each word into
// instruction memory. The core stays in reset until a load finishes with a
// correct checksum.
//
// Ports:
//   clk_RV            in   system clock, rising edge
//   reset             in   asynchronous active-high reset
//   iniciar           in   start-load request (ignored while ocupado=1)
//   byte_dato         in   stream byte
//   byte_valido       in   byte_dato is valid
//   byte_listo        out  loader accepts a byte this cycle
//   im_we             out  instruction-memory write enable
//   im_dir            out  instruction-memory word address
//   im_dato           out  instruction-memory write data
//   reset_nucleo      out  core reset, active-high
//   ocupado           out  load in progress
//   error             out  last load failed
//   palabras_cargadas out  words written in the current or last load
// -----------------------------------------------------------------------------
module cargador_programa #(
  parameter int ANCHO_DIR = 8
) (
  input  logic                 clk_RV,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic [7:0]           byte_dato,
  input  logic                 byte_valido,
  output logic                 byte_listo,
  output logic                 im_we,
  output logic [ANCHO_DIR-1:0] im_dir,
  output logic [31:0]          im_dato,
  output logic                 reset_nucleo,
  output logic                 ocupado,
  output logic                 error,
  output logic [ANCHO_DIR:0]   palabras_cargadas
);

  localparam int CAPACIDAD = 1 << ANCHO_DIR;

  typedef enum logic [2:0] {
    INACTIVO,
    LONG_L,
    LONG_H,
    DATOS,
    ESCRIBIR,
    CHECK,
    LISTO,
    FALLO
  } estado_t;

  estado_t              r_estado;
  logic [7:0]           r_n_bajo;
  logic [15:0]          r_n;
  logic [1:0]           r_carril;
  logic [23:0]          r_palabra;   // lanes 0..2; lane 3 goes straight to im_dato
  logic [7:0]           r_xor;
  logic [ANCHO_DIR:0]   r_palabras;  // doubles as the write word index
  logic                 r_im_we;
  logic [ANCHO_DIR-1:0] r_im_dir;
  logic [31:0]          r_im_dato;
  logic                 r_reset_nucleo;
  logic                 r_ocupado;
  logic                 r_error;

  logic                 w_acepta;
  logic [15:0]          w_n;
  logic                 w_n_ilegal;
  logic                 w_ultima;

  // Ready is a pure decode of the state register, so there is no
  // combinational path from byte_valido back to byte_listo.
  assign byte_listo = (r_estado == LONG_L) || (r_estado == LONG_H) ||
                      (r_estado == DATOS)  || (r_estado == CHECK);

  assign w_acepta   = byte_valido && byte_listo;
  assign w_n        = {byte_dato, r_n_bajo};
  assign w_n_ilegal = (w_n == 16'd0) || (32'(w_n) > CAPACIDAD);
  // True in ESCRIBIR when the word being written is the last one.
  assign w_ultima   = ((32'(r_palabras) + 32'd1) == 32'(r_n));

  always_ff @(posedge clk_RV or posedge reset) begin
    if (reset) begin
      r_estado       <= INACTIVO;
      r_n_bajo       <= '0;
      r_n            <= '0;
      r_carril       <= '0;
      r_palabra      <= '0;
      r_xor          <= '0;
      r_palabras     <= '0;
      r_im_we        <= 1'b0;
      r_im_dir       <= '0;
      r_im_dato      <= '0;
      r_reset_nucleo <= 1'b1;
      r_ocupado      <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      case (r_estado)
        INACTIVO, LISTO, FALLO: begin
          if (iniciar) begin
            r_estado       <= LONG_L;
            r_ocupado      <= 1'b1;
            r_reset_nucleo <= 1'b1;
            r_error        <= 1'b0;
            r_palabras     <= '0;
            r_carril       <= '0;
            r_xor          <= '0;
          end
        end

        LONG_L: begin
          if (w_acepta) begin
            r_n_bajo <= byte_dato;
            r_estado <= LONG_H;
          end
        end

        LONG_H: begin
          if (w_acepta) begin
            r_n <= w_n;
            if (w_n_ilegal) begin
              r_estado  <= FALLO;
              r_ocupado <= 1'b0;
              r_error   <= 1'b1;
            end else begin
              r_estado <= DATOS;
            end
          end
        end

        DATOS: begin
          if (w_acepta) begin
            r_xor    <= r_xor ^ byte_dato;
            r_carril <= r_carril + 2'd1;
            case (r_carril)
              2'd0: r_palabra[7:0]   <= byte_dato;
              2'd1: r_palabra[15:8]  <= byte_dato;
              2'd2: r_palabra[23:16] <= byte_dato;
              default: begin
                // Fourth byte completes the word: present it to memory now
                // so the write happens at the next edge.
                r_im_we   <= 1'b1;
                r_im_dir  <= r_palabras[ANCHO_DIR-1:0];
                r_im_dato <= {byte_dato, r_palabra};
                r_estado  <= ESCRIBIR;
              end
            endcase
          end
        end

        ESCRIBIR: begin
          r_im_we    <= 1'b0;
          r_palabras <= r_palabras + (ANCHO_DIR+1)'(1);
          r_estado   <= w_ultima ? CHECK : DATOS;
        end

        CHECK: begin
          if (w_acepta) begin
            r_ocupado <= 1'b0;
            if (byte_dato == r_xor) begin
              r_estado       <= LISTO;
              r_reset_nucleo <= 1'b0;
              r_error        <= 1'b0;
            end else begin
              r_estado       <= FALLO;
              r_reset_nucleo <= 1'b1;
              r_error        <= 1'b1;
            end
          end
        end

        default: r_estado <= INACTIVO;
      endcase
    end
  end

  assign im_we             = r_im_we;
  assign im_dir            = r_im_dir;
  assign im_dato           = r_im_dato;
  assign reset_nucleo      = r_reset_nucleo;
  assign ocupado           = r_ocupado;
  assign error             = r_error;
  assign palabras_cargadas = r_palabras;

endmodule

// File: tb/tb_cargador_programa.sv
// -----------------------------------------------------------------------------
// tb_cargador_programa
//
// Self-checking bench for cargador_programa. Expected memory writes are
// queued when a stream is built and compared as the loader writes them.
// -----------------------------------------------------------------------------
module tb_cargador_programa;

  localparam int AD = 8;

  logic          clk_RV = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar = 1'b0;
  logic [7:0]    byte_dato = 8'h00;
  logic          byte_valido = 1'b0;
  logic          byte_listo;
  logic          im_we;
  logic [AD-1:0] im_dir;
  logic [31:0]   im_dato;
  logic          reset_nucleo;
  logic          ocupado;
  logic          error;
  logic [AD:0]   palabras_cargadas;

  cargador_programa #(.ANCHO_DIR(AD)) dut (
    .clk_RV            (clk_RV),
    .reset             (reset),
    .iniciar           (iniciar),
    .byte_dato         (byte_dato),
    .byte_valido       (byte_valido),
    .byte_listo        (byte_listo),
    .im_we             (im_we),
    .im_dir            (im_dir),
    .im_dato           (im_dato),
    .reset_nucleo      (reset_nucleo),
    .ocupado           (ocupado),
    .error             (error),
    .palabras_cargadas (palabras_cargadas)
  );

  always #5 clk_RV = ~clk_RV;

  typedef struct packed {
    logic [AD-1:0] dir;
    logic [31:0]   dato;
  } esc_t;

  esc_t        sb[$];
  logic [7:0]  flujo[$];
  logic [31:0] palabras_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          ciclos;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs === esp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, esp);
  endtask

  // Write monitor: im_we is high for exactly one cycle per word.
  always @(negedge clk_RV) begin : monitor
    esc_t e;
    if (im_we === 1'b1) begin
      comprobar("listo_en_escribir", 32'(byte_listo), 32'd0);
      if (sb.size() == 0) begin
        comprobar("escritura_inesperada", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("write mem[%0d] = %08h (expected [%0d] = %08h)", im_dir, im_dato, e.dir, e.dato);
        comprobar("im_dir", 32'(im_dir), 32'(e.dir));
        comprobar("im_dato", im_dato, e.dato);
      end
    end
  end

  // Builds the stream for palabras_q with declared count n; optionally
  // corrupts the checksum and queues the expected writes.
  task automatic armar(input int n, input bit malo, input bit registrar);
    logic [7:0]  cs;
    logic [31:0] w;
    esc_t        e;
    cs = 8'h00;
    flujo.delete();
    flujo.push_back(8'(n));
    flujo.push_back(8'(n >> 8));
    foreach (palabras_q[i]) begin
      w = palabras_q[i];
      for (int k = 0; k < 4; k++) begin
        flujo.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
      if (registrar) begin
        e.dir  = AD'(i);
        e.dato = w;
        sb.push_back(e);
      end
    end
    flujo.push_back(malo ? (cs ^ 8'h03) : cs);
  endtask

  // Pulses iniciar, then offers the first max_bytes of flujo. Called and
  // returns at a falling edge. ciclos counts edges from iniciar to the edge
  // accepting the last byte, inclusive.
  task automatic enviar(input bit huecos, input bit pulso, input int max_bytes, output int c);
    int idx;
    int it;
    bit pulsado;
    idx = 0;
    it = 0;
    pulsado = 1'b0;
    iniciar = 1'b1;
    @(negedge clk_RV);
    iniciar = 1'b0;
    comprobar("ocupado_tras_iniciar", 32'(ocupado), 32'd1);
    comprobar("listo_tras_iniciar", 32'(byte_listo), 32'd1);
    while (idx < max_bytes && it < 5000) begin
      iniciar = 1'b0;
      if (pulso && !pulsado && idx >= 6) begin
        iniciar = 1'b1;
        pulsado = 1'b1;
      end
      byte_valido = huecos ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_dato   = flujo[idx];
      if (byte_valido && byte_listo) idx++;
      it++;
      @(negedge clk_RV);
    end
    byte_valido = 1'b0;
    iniciar = 1'b0;
    comprobar("bytes_enviados", 32'(idx), 32'(max_bytes));
    c = it + 1;
  endtask

  task automatic nominal(input bit huecos, input bit pulso, input string tag);
    palabras_q = '{32'h00500093, 32'h00108133};
    armar(2, 1'b0, 1'b1);
    enviar(huecos, pulso, flujo.size(), ciclos);
    $display("load %s: cycles=%0d words=%0d error=%0b reset_nucleo=%0b", tag, ciclos,
             palabras_cargadas, error, reset_nucleo);
    comprobar({tag, "_palabras"}, 32'(palabras_cargadas), 32'd2);
    comprobar({tag, "_error"}, 32'(error), 32'd0);
    comprobar({tag, "_reset_nucleo"}, 32'(reset_nucleo), 32'd0);
    comprobar({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    if (!huecos) comprobar({tag, "_ciclos"}, 32'(ciclos), 32'd14);
  endtask

  task automatic revisar_reset(input string tag);
    comprobar({tag, "_listo"}, 32'(byte_listo), 32'd0);
    comprobar({tag, "_we"}, 32'(im_we), 32'd0);
    comprobar({tag, "_reset_nucleo"}, 32'(reset_nucleo), 32'd1);
    comprobar({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    comprobar({tag, "_error"}, 32'(error), 32'd0);
    comprobar({tag, "_palabras"}, 32'(palabras_cargadas), 32'd0);
  endtask

  initial begin
    // Power-on reset.
    #1 reset = 1'b1;
    repeat (2) @(negedge clk_RV);
    revisar_reset("rst_inicial");
    comprobar("rst_inicial_dir", 32'(im_dir), 32'd0);
    comprobar("rst_inicial_dato", im_dato, 32'd0);
    reset = 1'b0;
    @(negedge clk_RV);

    // Nominal gap-free load.
    nominal(1'b0, 1'b0, "nominal");

    // Asynchronous reset between edges from LISTO, then held 3 cycles.
    #2 reset = 1'b1;
    #1;
    revisar_reset("rst_async");
    comprobar("rst_async_dir", 32'(im_dir), 32'd0);
    comprobar("rst_async_dato", im_dato, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_RV);
      comprobar("rst_mantenido_listo", 32'(byte_listo), 32'd0);
      comprobar("rst_mantenido_reset_nucleo", 32'(reset_nucleo), 32'd1);
    end
    reset = 1'b0;
    @(negedge clk_RV);

    // Bad checksum: writes happen, core stays in reset.
    palabras_q = '{32'h00500093, 32'h00108133};
    armar(2, 1'b1, 1'b1);
    enviar(1'b0, 1'b0, flujo.size(), ciclos);
    $display("load bad_checksum: error=%0b reset_nucleo=%0b", error, reset_nucleo);
    comprobar("malcs_error", 32'(error), 32'd1);
    comprobar("malcs_reset_nucleo", 32'(reset_nucleo), 32'd1);
    comprobar("malcs_ocupado", 32'(ocupado), 32'd0);
    comprobar("malcs_palabras", 32'(palabras_cargadas), 32'd2);
    nominal(1'b0, 1'b0, "tras_fallo");

    // N = 0 and N = 257 are rejected after the second length byte.
    flujo = '{8'h00, 8'h00};
    enviar(1'b0, 1'b0, 2, ciclos);
    $display("load n=0: error=%0b", error);
    comprobar("n0_error", 32'(error), 32'd1);
    comprobar("n0_ocupado", 32'(ocupado), 32'd0);
    comprobar("n0_listo", 32'(byte_listo), 32'd0);
    comprobar("n0_reset_nucleo", 32'(reset_nucleo), 32'd1);
    flujo = '{8'h01, 8'h01};
    enviar(1'b0, 1'b0, 2, ciclos);
    $display("load n=257: error=%0b", error);
    comprobar("n257_error", 32'(error), 32'd1);
    comprobar("n257_palabras", 32'(palabras_cargadas), 32'd0);

    // N = 256 fills the whole memory.
    palabras_q.delete();
    for (int i = 0; i < 256; i++) palabras_q.push_back($urandom);
    armar(256, 1'b0, 1'b1);
    enviar(1'b0, 1'b0, flujo.size(), ciclos);
    $display("load n=256: cycles=%0d words=%0d error=%0b", ciclos, palabras_cargadas, error);
    comprobar("n256_error", 32'(error), 32'd0);
    comprobar("n256_reset_nucleo", 32'(reset_nucleo), 32'd0);
    comprobar("n256_palabras", 32'(palabras_cargadas), 32'd256);
    comprobar("n256_ciclos", 32'(ciclos), 32'(4 + 5 * 256));

    // Backpressure with random valid and a stray iniciar mid-load.
    nominal(1'b1, 1'b1, "contrapresion");

    // Reset after 5 data bytes: only word 0 was written.
    palabras_q = '{32'h00500093, 32'h00108133};
    armar(2, 1'b0, 1'b0);
    sb.push_back({AD'(0), 32'h00500093});
    enviar(1'b0, 1'b0, 7, ciclos);
    #2 reset = 1'b1;
    #1;
    $display("reset after 5 data bytes: im_we=%0b reset_nucleo=%0b ocupado=%0b", im_we, reset_nucleo, ocupado);
    revisar_reset("rst_5bytes");
    @(negedge clk_RV);
    reset = 1'b0;
    @(negedge clk_RV);

    // Reset while im_we is high: it must drop without a clock.
    sb.push_back({AD'(0), 32'h00500093});
    enviar(1'b0, 1'b0, 6, ciclos);
    #1 comprobar("escribir_we_alto", 32'(im_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    $display("reset during write: im_we=%0b", im_we);
    revisar_reset("rst_escribir");
    @(negedge clk_RV);
    reset = 1'b0;
    @(negedge clk_RV);

    // Fresh load after the interrupted ones.
    nominal(1'b0, 1'b0, "tras_reset");

    comprobar("cola_vacia", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
